cam_sccb_sequencer: RTL and testbench

Camera configuration controller. On a start request it walks a register table of {register, value} entries held in an external synchronous ROM and issues each entry as an SCCB 3-phase write (device ID, register, value) to the OV7670. It brings the sensor into the mode the pixel capture path expects before frames are consumed. It sits between the top-level reset/start logic and the camera SIOC/SIOD pins, and runs on the system clock, not the camera pixel clock.

---
 rtl/cam_sccb_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cam_sccb_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_sccb_sequencer.sv
// OV7670 configuration sequencer: walks a {reg, val} table in an external
// synchronous ROM and issues each entry as a 3-phase SCCB write on sioc/siod.
module cam_sccb_sequencer #(
  parameter int          CLK_FREQ     = 25_000_000,
  parameter int          SCCB_FREQ    = 100_000,
  parameter logic [7:0]  CAM_ID       = 8'h42,
  parameter int          DELAY_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sioc,
  output logic        siod,
  output logic        busy,
  output logic        done
);

  localparam int QUARTER = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int DW      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0] QRELOAD = QW'(QUARTER - 1);
  localparam logic [DW-1:0] DRELOAD = DW'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, START, TX, STOP, GAP, DELAY, DONE
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [4:0]    bit_idx;
  logic [26:0]   shreg;
  logic [DW-1:0] dcnt;

  // NOTE: every register here is sequential state, so it is only ever assigned
  // with <=; blocking assignments would let later lines see same-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      sioc     <= 1'b1;
      siod     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      qcnt     <= '0;
      quarter  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      dcnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          done     <= 1'b0;
          rom_addr <= '0;
          state    <= FETCH;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (rom_data == 16'hFFFF) begin
            state <= DONE;
          end else if (rom_data == 16'hFFF0) begin
            dcnt  <= DRELOAD;
            state <= DELAY;
          end else begin
            // Each byte carries a trailing don't-care bit that the master holds high.
            shreg   <= {CAM_ID, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
            qcnt    <= QRELOAD;
            quarter <= '0;
            sioc    <= 1'b1;
            siod    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (qcnt == '0) begin
            qcnt <= QRELOAD;
            if (quarter == 2'd1) begin
              quarter <= '0;
              bit_idx <= '0;
              sioc    <= 1'b0;
              siod    <= shreg[26];
              state   <= TX;
            end else begin
              quarter <= quarter + 2'd1;
            end
          end else begin
            qcnt <= qcnt - QW'(1);
          end
        end
        TX: begin
          if (qcnt == '0) begin
            qcnt    <= QRELOAD;
            quarter <= quarter + 2'd1;
            case (quarter)
              2'd0: sioc <= 1'b0;
              2'd1: sioc <= 1'b1;
              2'd2: sioc <= 1'b1;
              default: begin
                sioc <= 1'b0;
                if (bit_idx == 5'd26) begin
                  siod  <= 1'b0;
                  state <= STOP;
                end else begin
                  bit_idx <= bit_idx + 5'd1;
                  shreg   <= {shreg[25:0], 1'b0};
                  siod    <= shreg[25];
                end
              end
            endcase
          end else begin
            qcnt <= qcnt - QW'(1);
          end
        end
        STOP: begin
          if (qcnt == '0) begin
            qcnt    <= QRELOAD;
            quarter <= quarter + 2'd1;
            case (quarter)
              2'd0: sioc  <= 1'b1;
              2'd1: siod  <= 1'b1;
              2'd3: state <= GAP;
              default: ;
            endcase
          end else begin
            qcnt <= qcnt - QW'(1);
          end
        end
        GAP: begin
          if (qcnt == '0) begin
            qcnt    <= QRELOAD;
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) begin
              // A table without a sentinel stops after entry 255 instead of wrapping.
              if (rom_addr == 8'd255) begin
                state <= DONE;
              end else begin
                rom_addr <= rom_addr + 8'd1;
                state    <= FETCH;
              end
            end
          end else begin
            qcnt <= qcnt - QW'(1);
          end
        end
        DELAY: begin
          if (dcnt == '0) begin
            if (rom_addr == 8'd255) begin
              state <= DONE;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
            end
          end else begin
            dcnt <= dcnt - DW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_sccb_sequencer.sv
// Self-checking bench for cam_sccb_sequencer: a bus monitor decodes SCCB frames
// and each scenario compares them against a queue of expected writes.
module tb_cam_sccb_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sioc, siod, busy, done;

  logic [15:0] rom [256];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [26:0] bits;
    logic [7:0]  nbits;
    int          start_cyc;
    int          stop_cyc;
  } frame_t;

  frame_t      got_q[$];
  logic [26:0] exp_q[$];
  logic [7:0]  addr_seq[$];

  // wait_done results
  bit w_timeout, w_busy_gap, busy_at_done;
  int done_cyc;

  cam_sccb_sequencer #(
    .CLK_FREQ    (400),
    .SCCB_FREQ   (100),
    .CAM_ID      (8'h42),
    .DELAY_CYCLES(20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sioc    (sioc),
    .siod    (siod),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom[rom_addr];
  end

  // Bus monitor: start/stop conditions and bit capture at sioc rising edges.
  logic        prev_sioc = 1'b1;
  logic        prev_siod = 1'b1;
  logic        m_active  = 1'b0;
  logic [26:0] m_bits    = '0;
  logic [7:0]  m_nbits   = '0;
  int          m_start   = 0;
  int          rise_cnt  = 0;
  int          stop_cnt  = 0;
  int          viol_cnt  = 0;

  always @(negedge clk) begin
    if (prev_sioc === 1'b1 && sioc === 1'b1 && prev_siod === 1'b1 && siod === 1'b0) begin
      m_active <= 1'b1;
      m_bits   <= '0;
      m_nbits  <= '0;
      m_start  <= cyc;
    end else if (prev_sioc === 1'b1 && sioc === 1'b1 && prev_siod === 1'b0 && siod === 1'b1) begin
      stop_cnt <= stop_cnt + 1;
      if (m_active) got_q.push_back({m_bits, m_nbits, m_start, cyc});
      m_active <= 1'b0;
    end else if (prev_sioc === 1'b0 && sioc === 1'b1) begin
      rise_cnt <= rise_cnt + 1;
      if (siod !== prev_siod) viol_cnt <= viol_cnt + 1;
      if (m_active && m_nbits < 8'd27) begin
        m_bits  <= {m_bits[25:0], siod};
        m_nbits <= m_nbits + 8'd1;
      end
    end
    prev_sioc <= sioc;
    prev_siod <= siod;
  end

  function automatic logic [26:0] make_frame(input logic [7:0] r, input logic [7:0] v);
    return {8'h42, 1'b1, r, 1'b1, v, 1'b1};
  endfunction

  task automatic rom_fill(input logic [15:0] fill);
    for (int i = 0; i < 256; i++) rom[i] = fill;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Polls at negedge until done, recording the rom_addr sequence; poke pulses start while busy.
  task automatic wait_done(input int budget, input bit poke);
    int k;
    bit fin;
    k = 0;
    fin = 1'b0;
    addr_seq.delete();
    w_timeout = 1'b0;
    w_busy_gap = 1'b0;
    while (!fin) begin
      if (addr_seq.size() == 0 || addr_seq[$] != rom_addr) addr_seq.push_back(rom_addr);
      if (done === 1'b1) begin
        start = 1'b0;
        done_cyc = cyc;
        busy_at_done = busy;
        fin = 1'b1;
      end else if (k >= budget) begin
        start = 1'b0;
        w_timeout = 1'b1;
        fin = 1'b1;
      end else begin
        if (busy !== 1'b1) w_busy_gap = 1'b1;
        start = poke && (k % 5 == 2);
        k++;
        @(negedge clk);
      end
    end
  endtask

  task automatic sb_drain(input int base, input string tag);
    int idx;
    logic [26:0] e;
    idx = base;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (idx >= got_q.size()) begin
        bad++; $display("FAIL %s_frame%0d: got none want %h", tag, idx - base, e);
      end else if (got_q[idx].bits !== e || got_q[idx].nbits != 8'd27) begin
        bad++; $display("FAIL %s_frame%0d: got %h/%0d bits want %h/27 bits",
                        tag, idx - base, got_q[idx].bits, got_q[idx].nbits, e);
      end
      idx++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;   // start alongside reset must be ignored
    repeat (3) @(negedge clk);
    total++; if (sioc !== 1'b1) begin bad++; $display("FAIL rst_sioc: got %b want 1", sioc); end
    total++; if (siod !== 1'b1) begin bad++; $display("FAIL rst_siod: got %b want 1", siod); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (rom_addr !== 8'd0) begin bad++; $display("FAIL rst_addr: got %0d want 0", rom_addr); end
    reset = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_single_write();
    int base, r0, s0, v0;
    rom_fill(16'h0000);
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    base = got_q.size(); r0 = rise_cnt; s0 = stop_cnt; v0 = viol_cnt;
    exp_q.push_back(make_frame(8'h12, 8'h80));
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy_latency: got %b want 1", busy); end
    total++; if (rom_addr !== 8'd0) begin bad++; $display("FAIL t1_addr0: got %0d want 0", rom_addr); end
    wait_done(500, 1'b0);
    total++; if (w_timeout) begin bad++; $display("FAIL t1_timeout: done never rose"); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL t1_busy_at_done: got %b want 0", busy_at_done); end
    total++; if (got_q.size() - base != 1) begin bad++; $display("FAIL t1_frame_count: got %0d want 1", got_q.size() - base); end
    total++; if (rise_cnt - r0 != 28) begin bad++; $display("FAIL t1_sioc_rises: got %0d want 28", rise_cnt - r0); end
    total++; if (stop_cnt - s0 != 1) begin bad++; $display("FAIL t1_stops: got %0d want 1", stop_cnt - s0); end
    total++; if (viol_cnt != v0) begin bad++; $display("FAIL t1_siod_at_rise: got %0d changes want 0", viol_cnt - v0); end
    if (got_q.size() > base) begin
      total++;
      if (got_q[base].stop_cyc - got_q[base].start_cyc != 112) begin
        bad++; $display("FAIL t1_frame_len: got %0d want 112", got_q[base].stop_cyc - got_q[base].start_cyc);
      end
      total++;
      if (done_cyc - got_q[base].stop_cyc != 9) begin
        bad++; $display("FAIL t1_done_latency: got %0d want 9", done_cyc - got_q[base].stop_cyc);
      end
    end
    sb_drain(base, "t1");
  endtask

  task automatic test_delay();
    int base;
    rom_fill(16'h0000);
    rom[0] = 16'h1180; rom[1] = 16'hFFF0; rom[2] = 16'h3A04; rom[3] = 16'hFFFF;
    base = got_q.size();
    exp_q.push_back(make_frame(8'h11, 8'h80));
    exp_q.push_back(make_frame(8'h3A, 8'h04));
    pulse_start();
    wait_done(800, 1'b0);
    total++; if (w_timeout) begin bad++; $display("FAIL t2_timeout: done never rose"); end
    total++; if (got_q.size() - base != 2) begin bad++; $display("FAIL t2_frame_count: got %0d want 2", got_q.size() - base); end
    if (got_q.size() - base >= 2) begin
      total++;
      if (got_q[base+1].start_cyc - got_q[base].stop_cyc != 30) begin
        bad++; $display("FAIL t2_delay_gap: got %0d want 30", got_q[base+1].start_cyc - got_q[base].stop_cyc);
      end
    end
    total++;
    if (addr_seq.size() != 4 || addr_seq[0] != 8'd0 || addr_seq[1] != 8'd1 ||
        addr_seq[2] != 8'd2 || addr_seq[3] != 8'd3) begin
      bad++; $display("FAIL t2_addr_seq: got %p want 0,1,2,3", addr_seq);
    end
    sb_drain(base, "t2");
  endtask

  task automatic test_start_while_busy();
    int base, extra_bad;
    rom_fill(16'h0000);
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    base = got_q.size();
    exp_q.push_back(make_frame(8'h12, 8'h80));
    pulse_start();
    wait_done(600, 1'b1);
    total++; if (w_timeout) begin bad++; $display("FAIL t3_timeout: done never rose"); end
    total++; if (w_busy_gap) begin bad++; $display("FAIL t3_busy_gap: busy dropped before done"); end
    total++;
    if (addr_seq.size() != 2 || addr_seq[0] != 8'd0 || addr_seq[1] != 8'd1) begin
      bad++; $display("FAIL t3_addr_seq: got %p want 0,1", addr_seq);
    end
    extra_bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b1 || busy !== 1'b0) extra_bad++;
    end
    total++; if (extra_bad != 0) begin bad++; $display("FAIL t3_done_once: got %0d bad idle cycles want 0", extra_bad); end
    total++; if (got_q.size() - base != 1) begin bad++; $display("FAIL t3_frame_count: got %0d want 1", got_q.size() - base); end
    sb_drain(base, "t3");
  endtask

  task automatic test_reset_mid_tx();
    int base, k;
    bit hit;
    rom_fill(16'h0000);
    rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
    base = got_q.size();
    pulse_start();
    hit = 1'b0;
    k = 0;
    while (!hit && k < 600) begin
      @(negedge clk);
      k++;
      hit = (got_q.size() > base) && (m_nbits >= 8'd10) && (sioc === 1'b0) && (siod === 1'b0);
    end
    total++; if (!hit) begin bad++; $display("FAIL t4_reach_byte2: not reached in %0d cycles", k); end
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    total++; if (sioc !== 1'b1) begin bad++; $display("FAIL t4_sioc: got %b want 1", sioc); end
    total++; if (siod !== 1'b1) begin bad++; $display("FAIL t4_siod: got %b want 1", siod); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL t4_done: got %b want 0", done); end
    total++; if (rom_addr !== 8'd0) begin bad++; $display("FAIL t4_addr: got %0d want 0", rom_addr); end
    reset = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_no_restart: busy got %b want 0", busy); end
    base = got_q.size();
    exp_q.push_back(make_frame(8'h12, 8'h80));
    exp_q.push_back(make_frame(8'h3A, 8'h04));
    pulse_start();
    wait_done(800, 1'b0);
    total++; if (w_timeout) begin bad++; $display("FAIL t4_timeout: done never rose"); end
    total++;
    if (addr_seq.size() != 3 || addr_seq[0] != 8'd0 || addr_seq[1] != 8'd1 || addr_seq[2] != 8'd2) begin
      bad++; $display("FAIL t4_addr_seq: got %p want 0,1,2", addr_seq);
    end
    total++; if (got_q.size() - base != 2) begin bad++; $display("FAIL t4_frame_count: got %0d want 2", got_q.size() - base); end
    sb_drain(base, "t4");
  endtask

  task automatic test_no_sentinel();
    int base, seq_bad;
    rom_fill(16'h0000);
    base = got_q.size();
    for (int i = 0; i < 256; i++) exp_q.push_back(make_frame(8'h00, 8'h00));
    pulse_start();
    wait_done(40000, 1'b0);
    total++; if (w_timeout) begin bad++; $display("FAIL t5_timeout: done never rose"); end
    total++; if (got_q.size() - base != 256) begin bad++; $display("FAIL t5_frame_count: got %0d want 256", got_q.size() - base); end
    seq_bad = 0;
    for (int i = 0; i < addr_seq.size(); i++) if (addr_seq[i] != 8'(i)) seq_bad++;
    total++;
    if (addr_seq.size() != 256 || seq_bad != 0) begin
      bad++; $display("FAIL t5_addr_seq: got %0d entries %0d out of order want 256 ascending", addr_seq.size(), seq_bad);
    end
    total++; if (rom_addr !== 8'd255) begin bad++; $display("FAIL t5_final_addr: got %0d want 255", rom_addr); end
    sb_drain(base, "t5");
  endtask

  task automatic test_back_to_back();
    int b1, b2;
    rom_fill(16'h0000);
    rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
    b1 = got_q.size();
    exp_q.push_back(make_frame(8'h12, 8'h80));
    exp_q.push_back(make_frame(8'h3A, 8'h04));
    pulse_start();
    wait_done(800, 1'b0);
    total++; if (w_timeout) begin bad++; $display("FAIL t6_pass1_timeout: done never rose"); end
    sb_drain(b1, "t6a");
    b2 = got_q.size();
    exp_q.push_back(make_frame(8'h12, 8'h80));
    exp_q.push_back(make_frame(8'h3A, 8'h04));
    @(negedge clk); start = 1'b1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL t6_done_before: got %b want 1", done); end
    @(negedge clk); start = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL t6_done_clear: got %b want 0", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t6_busy2: got %b want 1", busy); end
    wait_done(800, 1'b0);
    total++; if (w_timeout) begin bad++; $display("FAIL t6_pass2_timeout: done never rose"); end
    total++; if (got_q.size() - b2 != 2) begin bad++; $display("FAIL t6_frame_count: got %0d want 2", got_q.size() - b2); end
    if (got_q.size() - b2 >= 2) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_q[b2+i].bits !== got_q[b1+i].bits) begin
          bad++; $display("FAIL t6_same_stream%0d: got %h want %h", i, got_q[b2+i].bits, got_q[b1+i].bits);
        end
      end
    end
    sb_drain(b2, "t6b");
  endtask

  initial begin
    rom_fill(16'hFFFF);
    test_reset();
    test_single_write();
    test_delay();
    test_start_while_busy();
    test_reset_mid_tx();
    test_no_sentinel();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
